// File: rtl/magnitude_estimator_peak.sv
// Three-stage complex magnitude estimator with selectable per-sample approximation,
// followed by a windowed peak tracker that reports the largest magnitude and its index.
module magnitude_estimator_peak #(
  parameter int unsigned DATA_W  = 21,
  parameter int unsigned WIN_LEN = 64,
  parameter int unsigned IDX_W   = 6
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     DataEnable,
  input  logic signed [DATA_W-1:0] DataInRe,
  input  logic signed [DATA_W-1:0] DataInIm,
  input  logic [1:0]               Mode,
  input  logic                     WinClr,
  output logic                     AbsoluteEnable,
  output logic [DATA_W:0]          Absolute,
  output logic                     PeakValid,
  output logic [DATA_W:0]          PeakMag,
  output logic [IDX_W-1:0]         PeakIdx
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIN_LEN - 1);

  // Stage 1: absolute values; the most-negative input maps to 2^(DATA_W-1) unsigned
  logic [DATA_W-1:0] w_abs_re, w_abs_im;
  logic              r_v1;
  logic [1:0]        r_mode1;
  logic [DATA_W-1:0] r_abs_re1, r_abs_im1;

  assign w_abs_re = DataInRe[DATA_W-1] ? $unsigned(~DataInRe + DATA_W'(1)) : $unsigned(DataInRe);
  assign w_abs_im = DataInIm[DATA_W-1] ? $unsigned(~DataInIm + DATA_W'(1)) : $unsigned(DataInIm);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v1      <= 1'b0;
      r_mode1   <= '0;
      r_abs_re1 <= '0;
      r_abs_im1 <= '0;
    end else begin
      r_v1      <= DataEnable;
      r_mode1   <= DataEnable ? Mode : 2'b00;
      r_abs_re1 <= DataEnable ? w_abs_re : '0;
      r_abs_im1 <= DataEnable ? w_abs_im : '0;
    end
  end

  // Stage 2: ordering
  logic              r_v2;
  logic [1:0]        r_mode2;
  logic [DATA_W-1:0] r_mx2, r_mn2;
  logic              w_re_ge;

  assign w_re_ge = (r_abs_re1 >= r_abs_im1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v2    <= 1'b0;
      r_mode2 <= '0;
      r_mx2   <= '0;
      r_mn2   <= '0;
    end else begin
      r_v2    <= r_v1;
      r_mode2 <= r_v1 ? r_mode1 : 2'b00;
      r_mx2   <= r_v1 ? (w_re_ge ? r_abs_re1 : r_abs_im1) : '0;
      r_mn2   <= r_v1 ? (w_re_ge ? r_abs_im1 : r_abs_re1) : '0;
    end
  end

  // Stage 3: combine in DATA_W+1 bits with truncating logical shifts
  logic [DATA_W:0] w_mx, w_mn, w_mn_half, w_mx_eighth, w_comb;
  logic            r_v3;
  logic [DATA_W:0] r_abs3;

  assign w_mx        = {1'b0, r_mx2};
  assign w_mn        = {1'b0, r_mn2};
  assign w_mn_half   = w_mn >> 1;
  assign w_mx_eighth = w_mx >> 3;

  always_comb begin
    w_comb = '0;
    unique case (r_mode2)
      2'd0: w_comb = w_mx + w_mn;
      2'd1: w_comb = w_mx;
      2'd2: w_comb = w_mx + w_mn_half;
      2'd3: w_comb = w_mx - w_mx_eighth + w_mn_half;
      default: w_comb = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v3   <= 1'b0;
      r_abs3 <= '0;
    end else begin
      r_v3   <= r_v2;
      r_abs3 <= r_v2 ? w_comb : '0;
    end
  end

  assign AbsoluteEnable = r_v3;
  assign Absolute       = r_abs3;

  // Peak tracker; WinClr restarts the window with the coincident sample as index 0
  logic [IDX_W-1:0] r_cnt, r_cur_idx, r_peak_idx;
  logic [DATA_W:0]  r_cur_max, r_peak_mag;
  logic             r_peak_valid;
  logic [IDX_W-1:0] w_eff_cnt, w_new_idx;
  logic [DATA_W:0]  w_new_max;
  logic             w_last;

  assign w_eff_cnt = WinClr ? '0 : r_cnt;
  assign w_last    = !WinClr && (r_cnt == LastIdx);

  always_comb begin
    w_new_max = r_cur_max;
    w_new_idx = r_cur_idx;
    if (w_eff_cnt == '0) begin
      w_new_max = r_abs3;
      w_new_idx = '0;
    end else if (r_abs3 > r_cur_max) begin
      w_new_max = r_abs3;
      w_new_idx = w_eff_cnt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt        <= '0;
      r_cur_max    <= '0;
      r_cur_idx    <= '0;
      r_peak_valid <= 1'b0;
      r_peak_mag   <= '0;
      r_peak_idx   <= '0;
    end else begin
      r_peak_valid <= 1'b0;
      if (r_v3) begin
        r_cur_max <= w_new_max;
        r_cur_idx <= w_new_idx;
        if (w_last) begin
          r_cnt        <= '0;
          r_peak_valid <= 1'b1;
          r_peak_mag   <= w_new_max;
          r_peak_idx   <= w_new_idx;
        end else begin
          r_cnt <= w_eff_cnt + IDX_W'(1);
        end
      end else if (WinClr) begin
        r_cnt <= '0;
      end
    end
  end

  assign PeakValid = r_peak_valid;
  assign PeakMag   = r_peak_mag;
  assign PeakIdx   = r_peak_idx;

endmodule

// File: tb/tb_magnitude_estimator_peak.sv
// Directed bench for magnitude_estimator_peak: table-driven magnitude vectors plus
// hand-written peak-window, WinClr and mid-window reset sequences (WIN_LEN=4).
module tb_magnitude_estimator_peak;

  localparam int DW = 21;
  localparam int WL = 4;
  localparam int IW = 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          DataEnable;
  logic [DW-1:0] DataInRe, DataInIm;
  logic [1:0]    Mode;
  logic          WinClr;
  logic          AbsoluteEnable;
  logic [DW:0]   Absolute;
  logic          PeakValid;
  logic [DW:0]   PeakMag;
  logic [IW-1:0] PeakIdx;

  magnitude_estimator_peak #(
    .DATA_W (DW),
    .WIN_LEN(WL),
    .IDX_W  (IW)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .DataEnable    (DataEnable),
    .DataInRe      (DataInRe),
    .DataInIm      (DataInIm),
    .Mode          (Mode),
    .WinClr        (WinClr),
    .AbsoluteEnable(AbsoluteEnable),
    .Absolute      (Absolute),
    .PeakValid     (PeakValid),
    .PeakMag       (PeakMag),
    .PeakIdx       (PeakIdx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int en;
    int re;
    int im;
    int mode;
    int exp_en;
    int exp_abs;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   pulse_cnt = 0;

  always @(negedge Clk) if (PeakValid) pulse_cnt <= pulse_cnt + 1;

  function automatic vec_t mk(int en, int re, int im, int mode, int exp_en, int exp_abs);
    vec_t v;
    v.en = en; v.re = re; v.im = im; v.mode = mode; v.exp_en = exp_en; v.exp_abs = exp_abs;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int en, input int re, input int im, input int md, input int clr);
    @(posedge Clk);
    #1;
    DataEnable = (en != 0);
    DataInRe   = DW'(re);
    DataInIm   = DW'(im);
    Mode       = 2'(md);
    WinClr     = (clr != 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    DataEnable = 1'b0;
    WinClr = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int mags[6];
    Rst_n = 1'b0; DataEnable = 1'b0; DataInRe = '0; DataInIm = '0; Mode = '0; WinClr = 1'b0;

    // Table: mode sweep, mode-3 precision, zeros, extremes, enable gaps
    vecs.push_back(mk(1, -3, 4, 0, 1, 7));
    vecs.push_back(mk(1, -3, 4, 1, 1, 4));
    vecs.push_back(mk(1, -3, 4, 2, 1, 5));
    vecs.push_back(mk(1, -3, 4, 3, 1, 5));
    vecs.push_back(mk(1, 800, -600, 2, 1, 1100));
    vecs.push_back(mk(1, 800, -600, 3, 1, 1000));
    for (int m = 0; m < 4; m++) vecs.push_back(mk(1, 0, 0, m, 1, 0));
    vecs.push_back(mk(1, -1048576, -1048576, 0, 1, 2097152));
    vecs.push_back(mk(1, 1048575, 0, 1, 1, 1048575));
    vecs.push_back(mk(1, -1048576, 0, 3, 1, 917504));
    vecs.push_back(mk(1, 10, -7, 2, 1, 13));
    vecs.push_back(mk(1, 5, 0, 1, 1, 5));
    vecs.push_back(mk(0, 7, 7, 0, 0, 0));
    vecs.push_back(mk(1, 0, -6, 1, 1, 6));
    vecs.push_back(mk(1, 2, 1, 0, 1, 3));

    #12;
    check("reset_abs_en", AbsoluteEnable, 0);
    check("reset_abs", Absolute, 0);
    check("reset_peak_valid", PeakValid, 0);
    check("reset_peak_mag", PeakMag, 0);
    check("reset_peak_idx", PeakIdx, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < vecs.size() + 3; i++) begin
      if (i < vecs.size()) drive(vecs[i].en, vecs[i].re, vecs[i].im, vecs[i].mode, 0);
      else drive(0, 0, 0, 0, 0);
      @(negedge Clk);
      if (i >= 3) begin
        check($sformatf("vec%0d_en", i - 3), AbsoluteEnable, vecs[i-3].exp_en);
        check($sformatf("vec%0d_abs", i - 3), Absolute, vecs[i-3].exp_abs);
      end
    end

    // Peak window: 5,9,9,<idle>,2 -> one pulse, mag 9 idx 1
    do_reset();
    @(posedge Clk); #1;
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: drive(1, 5, 0, 1, 0);
        1, 2: drive(1, 9, 0, 1, 0);
        4: drive(1, 2, 0, 1, 0);
        default: drive(0, 0, 0, 0, 0);
      endcase
      @(negedge Clk);
      if (i == 7) begin
        check("peak_last_abs", Absolute, 2);
        check("peak_pre_valid", PeakValid, 0);
      end
      if (i == 8) begin
        check("peak_valid", PeakValid, 1);
        check("peak_mag", PeakMag, 9);
        check("peak_idx", PeakIdx, 1);
      end
      if (i == 9) begin
        check("peak_pulse_width", PeakValid, 0);
        check("peak_mag_hold", PeakMag, 9);
      end
    end
    @(posedge Clk); #1;
    check("peak_pulse_count", pulse_cnt - base, 1);

    // WinClr with 3rd sample: new window 9,2,6,1 -> mag 9 idx 0
    base = pulse_cnt;
    mags = '{3, 8, 9, 2, 6, 1};
    for (int i = 0; i < 10; i++) begin
      drive((i < 6) ? 1 : 0, (i < 6) ? mags[i] : 0, 0, 1, (i == 5) ? 1 : 0);
      @(negedge Clk);
      if (i == 7) check("clr_no_old_pulse", PeakValid, 0);
      if (i == 8) check("clr_pre_valid", PeakValid, 0);
      if (i == 9) begin
        check("clr_valid", PeakValid, 1);
        check("clr_mag", PeakMag, 9);
        check("clr_idx", PeakIdx, 0);
      end
    end
    @(posedge Clk); #1;
    check("clr_pulse_count", pulse_cnt - base, 1);

    // Mid-window reset: two counted samples, one in flight, then reset
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      drive((i < 3) ? 1 : 0, 5, 0, 1, 0);
      @(negedge Clk);
    end
    check("rst_pre_abs_en", AbsoluteEnable, 1);
    Rst_n = 1'b0;
    #1;
    check("rst_abs_en", AbsoluteEnable, 0);
    check("rst_abs", Absolute, 0);
    check("rst_peak_mag", PeakMag, 0);
    check("rst_peak_valid", PeakValid, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive((i < 3) ? 1 : 0, 4, 0, 1, 0);
      @(negedge Clk);
      if (i == 2) check("rst_resume_early", AbsoluteEnable, 0);
      if (i == 3) begin
        check("rst_resume_en", AbsoluteEnable, 1);
        check("rst_resume_abs", Absolute, 4);
      end
    end
    @(posedge Clk); #1;
    check("rst_no_pulse", pulse_cnt - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/magnitude_estimator_peak.md
Name: magnitude_estimator_peak

Overview:
- Parametrised, multi-mode complex magnitude estimator for the OFDM receive path.
- Converts a signed I/Q sample stream into an approximate magnitude, using a selectable approximation per sample.
- A windowed peak tracker reports the largest magnitude, and its index, in each window of WIN_LEN valid samples.
- Intended for coarse timing and synchronisation metrics.

Parameters:
- DATA_W, 21, width of the signed two's-complement inputs DataInRe and DataInIm.
- WIN_LEN, 64, number of valid output samples per peak window; must be ≥2.
- IDX_W, 6, width of the window index; must satisfy 2^IDX_W ≥ WIN_LEN.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- DataEnable  in  1  input sample valid.
- DataInRe  in  DATA_W  real part, signed.
- DataInIm  in  DATA_W  imaginary part, signed.
- Mode  in  2  approximation select, sampled together with each input sample.
- WinClr  in  1  synchronous window restart.
- AbsoluteEnable  out  1  output sample valid.
- Absolute  out  DATA_W+1  unsigned magnitude estimate.
- PeakValid  out  1  one-cycle pulse marking the end of a window.
- PeakMag  out  DATA_W+1  largest Absolute value in the completed window.
- PeakIdx  out  IDX_W  index within the window (0..WIN_LEN-1) of that peak.

Behaviour:
- Reset: Rst_n low asynchronously clears every register. All outputs are 0 and the window counter is 0.
- Pipeline: three register stages. Latency is exactly 3 cycles from DataEnable to AbsoluteEnable. There is no backpressure, so one sample per cycle is sustained.
- Stage 1 (absolute values): |Re| and |Im| are formed as DATA_W-bit unsigned values.
  - Negative inputs are negated as ~x+1 and read as unsigned.
  - The most-negative input, -2^(DATA_W-1), yields 2^(DATA_W-1) exactly, with no saturation.
  - Mode and the valid flag are registered alongside the data.
- Stage 2 (ordering): mx = max(|Re|,|Im|), mn = min(|Re|,|Im|). Mode and valid are carried along.
- Stage 3 (combine): result is zero-extended to DATA_W+1 bits, and all shifts are logical and truncating.
  - Mode 0: Absolute = |Re| + |Im| (computed as mx+mn).
  - Mode 1: Absolute = mx.
  - Mode 2: Absolute = mx + (mn>>1).
  - Mode 3: Absolute = mx - (mx>>3) + (mn>>1).
- Per-sample mode: each sample uses the Mode value captured with it. Mode changes mid-stream take effect on the next sample with no bubble.
- Invalid slots: a stage whose valid flag is 0 loads zeros, so Absolute=0 whenever AbsoluteEnable=0.
- Peak tracker: runs on the registered outputs (AbsoluteEnable, Absolute).
  - On each valid output it maintains cnt, curMax and curIdx.
  - cnt==0 loads curMax=Absolute and curIdx=0.
  - Otherwise, if Absolute > curMax (strictly greater), it loads curMax=Absolute and curIdx=cnt. Ties keep the first occurrence.
  - When the valid output has cnt==WIN_LEN-1, the next cycle PeakValid=1 and PeakMag/PeakIdx show the final max and index, including that last sample. cnt then wraps to 0.
  - PeakMag and PeakIdx hold their values until the next window completes. PeakValid is high for exactly one cycle.
- Gaps: cycles with AbsoluteEnable=0 do not advance cnt. Windows count valid samples, not cycles.
- WinClr:
  - Forces cnt=0 and discards the partial window; no PeakValid is produced for it.
  - If WinClr coincides with a valid output, that sample becomes index 0 of the new window.
  - If WinClr coincides with the final sample of a window, the new-window rule wins and PeakValid is suppressed.
  - WinClr does not affect the magnitude pipeline.
- Reset mid-operation: all in-flight samples and the partial window are lost. AbsoluteEnable resumes 3 cycles after the first DataEnable following reset release.

Test Plan:
- Mode sweep: Re=-3, Im=4, DataEnable for one cycle with Mode=0,1,2,3 on consecutive cycles → Absolute = 7, 4, 5, 5 on four consecutive cycles, starting 3 cycles after the first input.
- Mode 3 precision: Re=800, Im=-600 → Mode2 gives 1100, Mode3 gives 1000. Re=0, Im=0 → 0 in all modes.
- Extremes (DATA_W=21): Re=-1048576, Im=-1048576, Mode0 → Absolute=2097152, the MSB of the 22-bit output. Re=1048575, Im=0, Mode1 → 1048575.
- Enable gaps: DataEnable pattern 1,0,1,1 → AbsoluteEnable reproduces 1,0,1,1 delayed by 3 cycles, with Absolute=0 in the gap cycle.
- Peak window (WIN_LEN=4): magnitudes 5,9,9,2 with one idle cycle inserted after the 9s → a single PeakValid pulse one cycle after the sample 2, with PeakMag=9, PeakIdx=1.
- WinClr/reset: WinClr asserted with the 3rd of 4 samples, then 3 more samples → PeakValid only after the new window's 4th sample, with index 0 = the sample that coincided with WinClr. Rst_n pulsed mid-window → all outputs 0 immediately, and no PeakValid for the old window.
